// File: rtl/vending_credit.sv
// Coin-operated vending credit controller: accumulates coin credit, releases the
// product once PRICE is reached, and pays out any surplus or refund in CHANGE_UNIT pulses.
module vending_credit #(
    parameter int PRICE       = 15,
    parameter int COIN1       = 5,
    parameter int COIN2       = 10,
    parameter int COIN3       = 25,
    parameter int CHANGE_UNIT = 5,
    parameter int CREDIT_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        CHANGE  = 2'b11
    } state_t;

    // Coin sums are formed one bit wider than the credit register so overflow is visible.
    localparam logic [CREDIT_W:0]   COIN1_X  = (CREDIT_W+1)'(COIN1);
    localparam logic [CREDIT_W:0]   COIN2_X  = (CREDIT_W+1)'(COIN2);
    localparam logic [CREDIT_W:0]   COIN3_X  = (CREDIT_W+1)'(COIN3);
    localparam logic [CREDIT_W:0]   PRICE_X  = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X    = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] PRICE_W  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CHANGE_W = CREDIT_W'(CHANGE_UNIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = COIN1_X;
            2'b10:   coin_val = COIN2_X;
            2'b11:   coin_val = COIN3_X;
            default: coin_val = '0;
        endcase
        sum = {1'b0, credit_q} + coin_val;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                // Cancel takes priority over a simultaneous coin; only prior credit is refunded.
                if (state_q == COLLECT && cancel) begin
                    reject_d = (coin != 2'b00);
                    state_d  = (credit_q == '0) ? IDLE : CHANGE;
                end else if (coin != 2'b00) begin
                    if (sum > MAX_X) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_X) ? VEND : COLLECT;
                    end
                end
            end
            VEND: begin
                reject_d = (coin != 2'b00);
                if (credit_q <= PRICE_W) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - PRICE_W;
                    state_d  = CHANGE;
                end
            end
            CHANGE: begin
                reject_d = (coin != 2'b00);
                if (credit_q <= CHANGE_W) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - CHANGE_W;
                end
            end
            default: begin
                credit_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        dispense     = (state_q == VEND);
        change_pulse = (state_q == CHANGE);
        busy         = (state_q == VEND) || (state_q == CHANGE);
        credit       = credit_q;
        coin_reject  = reject_q;
    end

endmodule

// File: tb/tb_vending_credit.sv
// Self-checking bench for vending_credit: a per-cycle vector table on the default
// configuration and a hand-written overflow/refund sequence on a narrow-credit instance.
module tb_vending_credit;

    typedef struct {
        logic       rst;
        logic [1:0] coin;
        logic       cancel;
        logic       disp;
        logic       cp;
        logic [5:0] cr;
        logic       busy;
        logic       rej;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0, cancel0 = 1'b0;
    logic [1:0] coin0 = 2'b00;
    logic       disp0, cp0, busy0, rej0;
    logic [5:0] cr0;
    logic       rst1 = 1'b0, cancel1 = 1'b0;
    logic [1:0] coin1 = 2'b00;
    logic       disp1, cp1, busy1, rej1;
    logic [4:0] cr1;

    int   applied = 0;
    int   miscompares = 0;
    vec_t table0[$];
    vec_t table1[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    vending_credit u0 (
        .clk(clk), .rst(rst0), .coin(coin0), .cancel(cancel0),
        .dispense(disp0), .change_pulse(cp0), .credit(cr0), .busy(busy0), .coin_reject(rej0)
    );

    vending_credit #(.PRICE(30), .CREDIT_W(5)) u1 (
        .clk(clk), .rst(rst1), .coin(coin1), .cancel(cancel1),
        .dispense(disp1), .change_pulse(cp1), .credit(cr1), .busy(busy1), .coin_reject(rej1)
    );

    function automatic vec_t mk(logic r, logic [1:0] c, logic k,
                                logic d, logic p, logic [5:0] cr, logic b, logic j);
        vec_t v;
        v.rst = r; v.coin = c; v.cancel = k;
        v.disp = d; v.cp = p; v.cr = cr; v.busy = b; v.rej = j;
        return v;
    endfunction

    task automatic cmp(string name, int idx, logic [5:0] act, logic [5:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector on the selected DUT, queue its expectation, check after the edge.
    task automatic step(input int sel, input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        if (sel == 0) begin
            rst0 = v.rst; coin0 = v.coin; cancel0 = v.cancel;
        end else begin
            rst1 = v.rst; coin1 = v.coin; cancel1 = v.cancel;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        applied++;
        if (sel == 0) begin
            cmp("u0.dispense", idx, {5'd0, disp0}, {5'd0, e.disp});
            cmp("u0.change_pulse", idx, {5'd0, cp0}, {5'd0, e.cp});
            cmp("u0.credit", idx, cr0, e.cr);
            cmp("u0.busy", idx, {5'd0, busy0}, {5'd0, e.busy});
            cmp("u0.coin_reject", idx, {5'd0, rej0}, {5'd0, e.rej});
        end else begin
            cmp("u1.dispense", idx, {5'd0, disp1}, {5'd0, e.disp});
            cmp("u1.change_pulse", idx, {5'd0, cp1}, {5'd0, e.cp});
            cmp("u1.credit", idx, {1'b0, cr1}, e.cr);
            cmp("u1.busy", idx, {5'd0, busy1}, {5'd0, e.busy});
            cmp("u1.coin_reject", idx, {5'd0, rej1}, {5'd0, e.rej});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        //                    rst coin  cxl  disp cp  credit busy rej
        // reset, inputs ignored while held
        table0.push_back(mk(0, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        table0.push_back(mk(0, 2'b11, 1,   0, 0, 6'd0,  0, 0));
        // 5+5+5: exact price, no change
        table0.push_back(mk(1, 2'b01, 0,   0, 0, 6'd5,  0, 0));
        table0.push_back(mk(1, 2'b01, 0,   0, 0, 6'd10, 0, 0));
        table0.push_back(mk(1, 2'b01, 0,   1, 0, 6'd15, 1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // 10+10: one change pulse
        table0.push_back(mk(1, 2'b10, 0,   0, 0, 6'd10, 0, 0));
        table0.push_back(mk(1, 2'b10, 0,   1, 0, 6'd20, 1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 1, 6'd5,  1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // 25: two change pulses
        table0.push_back(mk(1, 2'b11, 0,   1, 0, 6'd25, 1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 1, 6'd10, 1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 1, 6'd5,  1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // 10 then cancel; coin during CHANGE rejected
        table0.push_back(mk(1, 2'b10, 0,   0, 0, 6'd10, 0, 0));
        table0.push_back(mk(1, 2'b00, 1,   0, 1, 6'd10, 1, 0));
        table0.push_back(mk(1, 2'b01, 0,   0, 1, 6'd5,  1, 1));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // cancel and coin together in COLLECT
        table0.push_back(mk(1, 2'b01, 0,   0, 0, 6'd5,  0, 0));
        table0.push_back(mk(1, 2'b10, 1,   0, 1, 6'd5,  1, 1));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // cancel ignored in IDLE, VEND, CHANGE
        table0.push_back(mk(1, 2'b00, 1,   0, 0, 6'd0,  0, 0));
        table0.push_back(mk(1, 2'b11, 0,   1, 0, 6'd25, 1, 0));
        table0.push_back(mk(1, 2'b01, 1,   0, 1, 6'd10, 1, 1));
        table0.push_back(mk(1, 2'b00, 1,   0, 1, 6'd5,  1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // reset during first change pulse
        table0.push_back(mk(1, 2'b11, 0,   1, 0, 6'd25, 1, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 1, 6'd10, 1, 0));
        table0.push_back(mk(0, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // reset during VEND
        table0.push_back(mk(1, 2'b11, 0,   1, 0, 6'd25, 1, 0));
        table0.push_back(mk(0, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        table0.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));

        for (int i = 0; i < table0.size(); i++)
            step(0, i, table0[i]);

        // Narrow instance (PRICE=30, 5-bit credit): overflow reject, then cancel refund of 25
        table1.push_back(mk(0, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        table1.push_back(mk(1, 2'b11, 0,   0, 0, 6'd25, 0, 0));
        table1.push_back(mk(1, 2'b11, 0,   0, 0, 6'd25, 0, 1));
        table1.push_back(mk(1, 2'b00, 1,   0, 1, 6'd25, 1, 0));
        table1.push_back(mk(1, 2'b00, 0,   0, 1, 6'd20, 1, 0));
        table1.push_back(mk(1, 2'b00, 0,   0, 1, 6'd15, 1, 0));
        table1.push_back(mk(1, 2'b00, 0,   0, 1, 6'd10, 1, 0));
        table1.push_back(mk(1, 2'b00, 0,   0, 1, 6'd5,  1, 0));
        table1.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));
        // 25 + 5 reaches exact price after an earlier reject
        table1.push_back(mk(1, 2'b11, 0,   0, 0, 6'd25, 0, 0));
        table1.push_back(mk(1, 2'b01, 0,   1, 0, 6'd30, 1, 0));
        table1.push_back(mk(1, 2'b00, 0,   0, 0, 6'd0,  0, 0));

        for (int i = 0; i < table1.size(); i++)
            step(1, i, table1[i]);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
